// File: rtl/clarvi_part_collector_if.sv
// clarvi_part_collector_if
//   Bundles the writeback part stream, the flush/clear controls and the
//   assembled register-file write of clarvi_part_collector.
//   master : drives the part stream and controls (WB stage / testbench)
//   slave  : the collector itself
// Signals
//   in_valid, in_part, in_data, in_rd, in_wb_en, in_is32 : one slice result
//   flush, clear_error                                   : control
//   out_valid, out_we, out_rd, out_value                 : 64-bit commit
//   part_error                                           : sticky error flag
interface clarvi_part_collector_if #(
  parameter int SLICE_W = 16,
  parameter int NPARTS  = 4
);
  localparam int PART_W = $clog2(NPARTS);
  localparam int XLEN   = SLICE_W * NPARTS;

  logic                 in_valid;
  logic [PART_W-1:0]    in_part;
  logic [SLICE_W-1:0]   in_data;
  logic [4:0]           in_rd;
  logic                 in_wb_en;
  logic                 in_is32;
  logic                 flush;
  logic                 clear_error;
  logic                 out_valid;
  logic                 out_we;
  logic [4:0]           out_rd;
  logic [XLEN-1:0]      out_value;
  logic                 part_error;

  modport master (
    output in_valid, in_part, in_data, in_rd, in_wb_en, in_is32, flush, clear_error,
    input  out_valid, out_we, out_rd, out_value, part_error
  );

  modport slave (
    input  in_valid, in_part, in_data, in_rd, in_wb_en, in_is32, flush, clear_error,
    output out_valid, out_we, out_rd, out_value, part_error
  );
endinterface

// File: rtl/clarvi_part_collector.sv
// clarvi_part_collector
//   Writeback-side reassembler for the 16-bit sliced datapath. Each RV64
//   instruction arrives as NPARTS slice results in any order; once every
//   slice has landed, one 64-bit register write and a retire pulse are
//   emitted on the following cycle.
// Ports
//   clock : system clock
//   reset : asynchronous, active-high
//   bus   : clarvi_part_collector_if.slave (part stream in, commit out)
// Configuration
//   CLARVI_WB_SEXT32_EN : when defined, OP_32 results get bits 63:32
//     replaced by the sign of bit 31; otherwise the buffer is passed through.
//
// state   | meaning
// IDLE    | no instruction in flight
// COLLECT | some slices of an instruction received
// COMMIT  | out_valid pulse cycle; may also accept the next first slice
module clarvi_part_collector #(
  parameter int SLICE_W = 16,
  parameter int NPARTS  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  clarvi_part_collector_if.slave bus
);
  localparam int XLEN   = SLICE_W * NPARTS;
  localparam int PART_W = $clog2(NPARTS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  localparam logic [NPARTS-1:0] MASK_FULL = {NPARTS{1'b1}};
  localparam logic [NPARTS-1:0] MASK_ONE  = {{(NPARTS-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [NPARTS-1:0] mask;
  logic [XLEN-1:0]   data_buf;
  logic [4:0]        rd_q;
  logic              wb_en_q;
  logic              is32_q;

  logic              in_go;
  logic              accept_first;
  logic              in_collect;
  logic              bad_beat;
  logic              err_evt;
  logic              accept;
  logic [NPARTS-1:0] part_onehot;
  logic [NPARTS-1:0] mask_acc;
  logic              complete;
  logic [XLEN-1:0]   buf_next;
  logic [XLEN-1:0]   commit_value;

  // flush kills any beat presented in the same cycle
  assign in_go        = bus.in_valid && !bus.flush;
  assign in_collect   = (state == ST_COLLECT);
  assign accept_first = in_go && !in_collect;

  assign part_onehot = MASK_ONE << bus.in_part;
  assign bad_beat    = ((mask & part_onehot) != '0) ||
                       (bus.in_rd != rd_q) ||
                       (bus.in_wb_en != wb_en_q) ||
                       (bus.in_is32 != is32_q);
  assign err_evt     = in_go && in_collect && bad_beat;
  assign accept      = accept_first || (in_go && in_collect && !bad_beat);

  assign mask_acc = (accept_first ? '0 : mask) | part_onehot;
  assign complete = accept && (mask_acc == MASK_FULL);

  always_comb begin
    buf_next = data_buf;
    if (accept) begin
      buf_next[int'(bus.in_part)*SLICE_W +: SLICE_W] = bus.in_data;
    end
  end

  // An accepted completing beat always matches the captured rd/wb_en/is32,
  // so the live inputs can be used directly for the commit.
`ifdef CLARVI_WB_SEXT32_EN
  assign commit_value = bus.in_is32 ? {{(XLEN-32){buf_next[31]}}, buf_next[31:0]} : buf_next;
`else
  assign commit_value = buf_next;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mask     <= '0;
      data_buf <= '0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      is32_q   <= 1'b0;
    end else begin
      data_buf <= buf_next;
      if (accept_first) begin
        rd_q    <= bus.in_rd;
        wb_en_q <= bus.in_wb_en;
        is32_q  <= bus.in_is32;
      end

      if (bus.flush) begin
        state <= ST_IDLE;
        mask  <= '0;
      end else if (complete) begin
        state <= ST_COMMIT;
        mask  <= '0;
      end else if (accept) begin
        state <= ST_COLLECT;
        mask  <= mask_acc;
      end else if (state == ST_COMMIT) begin
        state <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_we    <= 1'b0;
      bus.out_rd    <= '0;
      bus.out_value <= '0;
    end else begin
      bus.out_valid <= complete;
      bus.out_we    <= complete && bus.in_wb_en && (bus.in_rd != 5'd0);
      if (complete) begin
        bus.out_rd    <= bus.in_rd;
        bus.out_value <= commit_value;
      end
    end
  end

  // error set wins over a simultaneous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.part_error <= 1'b0;
    end else if (err_evt) begin
      bus.part_error <= 1'b1;
    end else if (bus.clear_error) begin
      bus.part_error <= 1'b0;
    end
  end
endmodule
